// File: rtl/lab1_imul_mul_arbiter.sv
// lab1_imul_mul_arbiter: round-robin sharing of one in-order multiplier among NREQ requesters
module lab1_imul_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int MAX_OUT = 2,
    localparam int TW = $clog2(NREQ),
    localparam int OW = $clog2(MAX_OUT) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NREQ-1:0]    i_req_val,
    output logic [NREQ-1:0]    o_req_rdy,
    input  logic [NREQ*64-1:0] i_req_msg,
    output logic [NREQ-1:0]    o_resp_val,
    input  logic [NREQ-1:0]    i_resp_rdy,
    output logic [31:0]        o_resp_msg,
    output logic               o_mul_istream_val,
    input  logic               i_mul_istream_rdy,
    output logic [63:0]        o_mul_istream_msg,
    input  logic               i_mul_ostream_val,
    output logic               o_mul_ostream_rdy,
    input  logic [31:0]        i_mul_ostream_msg,
    output logic [OW-1:0]      o_outstanding
);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [AW-1:0] LAST = AW'(MAX_OUT - 1);
    localparam logic [TW-1:0] PLAST = TW'(NREQ - 1);
    localparam logic [OW-1:0] FULL = OW'(MAX_OUT);

    logic [TW-1:0]     r_ptr;
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [OW-1:0]     r_count;
    logic [TW-1:0]     r_tags [MAX_OUT];
    logic [2*NREQ-1:0] w_rot;
    logic [TW-1:0]     w_gnt;
    logic              w_gnt_val;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [TW-1:0]     w_tag;
    logic [NREQ-1:0]   w_gnt_oh;
    logic [NREQ-1:0]   w_tag_oh;

    // Rotate requests so offset 0 is the pointer; the smallest valid offset wins.
    always_comb begin
        w_rot = {i_req_val, i_req_val} >> r_ptr;
        w_gnt_val = 1'b0;
        w_gnt = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_gnt_val = 1'b1;
                w_gnt = TW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_full = r_count == FULL;
    assign w_empty = r_count == '0;
    assign w_tag = r_tags[r_head];
    assign w_gnt_oh = NREQ'(1) << w_gnt;
    assign w_tag_oh = NREQ'(1) << w_tag;

    // Requests go straight through; holding reset low silences every handshake output.
    assign o_mul_istream_val = i_reset && w_gnt_val && !w_full;
    assign o_mul_istream_msg = i_req_msg[64*w_gnt +: 64];
    assign w_push = o_mul_istream_val && i_mul_istream_rdy;
    assign o_req_rdy = w_push ? w_gnt_oh : '0;

    // Results are steered to the requester recorded at the tag FIFO head.
    assign o_resp_val = (i_reset && i_mul_ostream_val && !w_empty) ? w_tag_oh : '0;
    assign o_mul_ostream_rdy = i_reset && !w_empty && i_resp_rdy[w_tag];
    assign w_pop = o_mul_ostream_rdy && i_mul_ostream_val;
    assign o_resp_msg = i_mul_ostream_msg;
    assign o_outstanding = r_count;

    // Advance the round-robin pointer past each issued requester and track FIFO occupancy.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ptr <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_ptr <= (w_gnt == PLAST) ? '0 : w_gnt + 1'b1;
                r_tail <= (r_tail == LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) r_head <= (r_head == LAST) ? '0 : r_head + 1'b1;
            r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                       (w_pop && !w_push) ? r_count - 1'b1 : r_count;
        end
    end

    // Tag storage is unreset; only entries between head and tail are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_tags[r_tail] <= w_gnt;
    end
endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// tb_lab1_imul_mul_arbiter: directed and random checks of the multiplier arbiter
module tb_lab1_imul_mul_arbiter;
    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_val;
    logic [3:0]   req_rdy;
    logic [255:0] req_msg;
    logic [3:0]   resp_val;
    logic [3:0]   resp_rdy;
    logic [31:0]  resp_msg;
    logic         is_val;
    logic         is_rdy;
    logic [63:0]  is_msg;
    logic         os_val;
    logic         os_rdy;
    logic [31:0]  os_msg;
    logic [1:0]   outstanding;

    int total = 0;
    int bad = 0;

    logic [31:0] m_prod [0:7];
    int          m_due [0:7];
    int          m_h, m_t, m_n, cyc;
    int          m_lat = 1;
    int          m_cap = 8;
    logic        m_en = 1'b1;

    vec_t        vecs [10];
    logic [31:0] rr_prod [4];
    logic [31:0] sb [0:3][0:127];
    int          wp [4];
    int          rp [4];
    logic [31:0] cur_p [4];
    logic [3:0]  fired;
    int          started, issued, got, ni, nr, issue_cyc;
    logic        seen;
    logic [31:0] ra, rb;

    always #5 clk = ~clk;

    lab1_imul_mul_arbiter dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_req_val(req_val),
        .o_req_rdy(req_rdy),
        .i_req_msg(req_msg),
        .o_resp_val(resp_val),
        .i_resp_rdy(resp_rdy),
        .o_resp_msg(resp_msg),
        .o_mul_istream_val(is_val),
        .i_mul_istream_rdy(is_rdy),
        .o_mul_istream_msg(is_msg),
        .i_mul_ostream_val(os_val),
        .o_mul_ostream_rdy(os_rdy),
        .i_mul_ostream_msg(os_msg),
        .o_outstanding(outstanding)
    );

    // Behavioural in-order multiplier with fixed latency m_lat and room for m_cap operations.
    assign is_rdy = m_en && (m_n < m_cap);
    assign os_val = (m_n > 0) && (m_due[m_h] <= cyc);
    assign os_msg = m_prod[m_h];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0;
            m_h <= 0;
            m_t <= 0;
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (is_val && is_rdy) begin
                m_prod[m_t] <= is_msg[63:32] * is_msg[31:0];
                m_due[m_t] <= cyc + m_lat;
                m_t <= (m_t + 1) % 8;
            end
            if (os_val && os_rdy) m_h <= (m_h + 1) % 8;
            m_n <= m_n + int'(is_val && is_rdy) - int'(os_val && os_rdy);
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_one(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        logic hit;
        hit = 1'b0;
        @(negedge clk);
        req_val = 4'(1 << idx);
        req_msg[idx*64 +: 64] = {a, b};
        for (int c = 0; c < 20 && !hit; c++) begin
            #1;
            if (req_rdy != 4'b0) begin
                hit = 1'b1;
                check("one_req_rdy", req_rdy, 64'(1 << idx));
            end
            @(negedge clk);
        end
        req_val = 4'b0;
        check("one_issued", hit, 1);
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            #1;
            if (resp_val != 4'b0) begin
                hit = 1'b1;
                check("one_resp_val", resp_val, 64'(1 << idx));
                check("one_resp_msg", resp_msg, p);
            end
            @(negedge clk);
        end
        check("one_resp_seen", hit, 1);
        check("one_ptr", dut.r_ptr, 64'((idx + 1) % 4));
        check("one_outstanding", outstanding, 0);
    endtask

    initial begin
        vecs[0] = '{2, 32'd7648, 32'd7648, 32'd58491904};
        vecs[1] = '{1, 32'd4096, 32'd2048, 32'd8388608};
        vecs[2] = '{0, 32'd3, 32'd5, 32'd15};
        vecs[3] = '{3, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE};
        vecs[4] = '{1, 32'd65536, 32'd65536, 32'd0};
        vecs[5] = '{0, 32'd0, 32'd12345, 32'd0};
        vecs[6] = '{3, 32'd1000, 32'd1000, 32'd1000000};
        vecs[7] = '{2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
        vecs[8] = '{1, 32'd12345, 32'd6789, 32'd83810205};
        vecs[9] = '{0, 32'h80000000, 32'd3, 32'h80000000};
        rr_prod = '{32'd700, 32'd1414, 32'd2142, 32'd2884};

        // Reset with every requester asking and the multiplier ready: all handshakes must stay low.
        rst_n = 1'b0;
        req_val = 4'hF;
        resp_rdy = 4'hF;
        req_msg = '0;
        for (int i = 0; i < 4; i++) req_msg[i*64 +: 64] = {32'(100 + i), 32'(7 * (i + 1))};
        repeat (2) @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_is_val", is_val, 0);
        check("rst_os_rdy", os_rdy, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_ptr", dut.r_ptr, 0);

        // All four requesters held valid from reset: grants rotate 0,1,2,3 at one per cycle.
        rst_n = 1'b1;
        ni = 0;
        nr = 0;
        issue_cyc = 0;
        for (int c = 0; c < 40 && nr < 8; c++) begin
            #1;
            if (req_rdy != 4'b0) begin
                check("rr_grant", req_rdy, 64'(1 << (ni % 4)));
                ni++;
                if (ni == 8) issue_cyc = c + 1;
            end
            if (resp_val != 4'b0) begin
                check("rr_resp_port", resp_val, 64'(1 << (nr % 4)));
                check("rr_resp_msg", resp_msg, rr_prod[nr % 4]);
                nr++;
            end
            @(negedge clk);
            if (ni >= 8) req_val = 4'b0;
        end
        check("rr_issues", ni, 8);
        check("rr_resps", nr, 8);
        check("rr_throughput", issue_cyc, 8);

        // Table of single-requester transactions.
        for (int v = 0; v < 10; v++) do_one(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].p);

        // Back-pressure on port 1 fills the FIFO; the third issue must wait.
        @(negedge clk);
        resp_rdy = 4'b1101;
        req_val = 4'b0010;
        req_msg[127:64] = {32'd4096, 32'd2048};
        #1;
        check("bp_rdy1", req_rdy, 4'b0010);
        @(negedge clk);
        req_val = 4'b1100;
        req_msg[191:128] = {32'd3, 32'd7};
        req_msg[255:192] = {32'd9, 32'd9};
        #1;
        check("bp_rdy2", req_rdy, 4'b0100);
        check("bp_resp_early", resp_val, 4'b0010);
        @(negedge clk);
        req_val = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("bp_resp_val", resp_val, 4'b0010);
            check("bp_resp_msg", resp_msg, 32'd8388608);
            check("bp_os_rdy", os_rdy, 0);
            check("bp_is_val", is_val, 0);
            check("bp_req_rdy", req_rdy, 0);
            check("bp_outstanding", outstanding, 2);
            @(negedge clk);
        end
        // Releasing the stall pops while full: no issue in the same cycle, issue on the next.
        resp_rdy = 4'hF;
        #1;
        check("fp_pop", os_rdy, 1);
        check("fp_resp", resp_val, 4'b0010);
        check("fp_no_issue", is_val, 0);
        check("fp_no_rdy", req_rdy, 0);
        @(negedge clk);
        #1;
        check("fp_issue", req_rdy, 4'b1000);
        check("fp_resp2", resp_val, 4'b0100);
        check("fp_msg2", resp_msg, 32'd21);
        @(negedge clk);
        req_val = 4'b0;
        #1;
        check("fp_resp3", resp_val, 4'b1000);
        check("fp_msg3", resp_msg, 32'd81);
        @(negedge clk);
        check("fp_drained", outstanding, 0);

        // Reset in the middle of two outstanding operations.
        resp_rdy = 4'b0;
        req_val = 4'b0001;
        req_msg[63:0] = {32'd11, 32'd13};
        req_msg[127:64] = {32'd17, 32'd19};
        #1;
        check("mr_rdy0", req_rdy, 4'b0001);
        @(negedge clk);
        req_val = 4'b0010;
        #1;
        check("mr_rdy1", req_rdy, 4'b0010);
        @(negedge clk);
        req_val = 4'b0011;
        resp_rdy = 4'hF;
        #1;
        check("mr_full", outstanding, 2);
        rst_n = 1'b0;
        #1;
        check("mr_req_rdy", req_rdy, 0);
        check("mr_resp_val", resp_val, 0);
        check("mr_is_val", is_val, 0);
        check("mr_os_rdy", os_rdy, 0);
        check("mr_outstanding", outstanding, 0);
        repeat (2) @(negedge clk);
        req_val = 4'b0;
        rst_n = 1'b1;
        #1;
        check("mr_ptr", dut.r_ptr, 0);
        check("mr_outstanding_rel", outstanding, 0);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (resp_val != 4'b0) seen = 1'b1;
        end
        check("mr_no_stale_resp", seen, 0);

        // Random operands on random ports with random response and multiplier stalls.
        m_lat = 2;
        started = 0;
        issued = 0;
        got = 0;
        fired = 4'b0;
        for (int i = 0; i < 4; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        for (int c = 0; c < 5000 && got < 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (fired[i]) begin
                    req_val[i] = 1'b0;
                    fired[i] = 1'b0;
                end
                if (!req_val[i] && started < 100 && $urandom_range(0, 1) == 1) begin
                    ra = $urandom;
                    rb = $urandom;
                    req_msg[i*64 +: 64] = {ra, rb};
                    cur_p[i] = ra * rb;
                    req_val[i] = 1'b1;
                    started++;
                end
            end
            resp_rdy = 4'($urandom);
            m_en = $urandom_range(0, 3) != 0;
            #1;
            if ($countones(resp_val) > 1 || $countones(req_rdy) > 1)
                check("rnd_onehot", {resp_val, req_rdy}, 0);
            for (int i = 0; i < 4; i++) begin
                if (req_rdy[i]) begin
                    sb[i][wp[i] % 128] = cur_p[i];
                    wp[i]++;
                    fired[i] = 1'b1;
                    issued++;
                end
                if (resp_val[i] && resp_rdy[i]) begin
                    check("rnd_pending", wp[i] > rp[i], 1);
                    check("rnd_prod", resp_msg, sb[i][rp[i] % 128]);
                    rp[i]++;
                    got++;
                end
            end
        end
        req_val = 4'b0;
        check("rnd_issued", issued, 100);
        check("rnd_got", got, 100);
        @(negedge clk);
        check("rnd_outstanding", outstanding, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lab1_imul_mul_arbiter.md
# lab1_imul_mul_arbiter

Round-robin arbiter that shares one latency-insensitive integer multiplier (64-bit operand message in, 32-bit product out) among NREQ requesters. It sits between the requester-side val/rdy streams and the multiplier's istream/ostream ports. A tag FIFO records the requester for each operation in flight, and each result is steered back to that requester's response port. With the iterative multiplier, MAX_OUT = 1 is sufficient; a pipelined multiplier may use more.

## Interface
- NREQ, 4: number of requesters, 2..8; TW = $clog2(NREQ).
- MAX_OUT, 2: tag FIFO depth (max operations in flight), power of two, 1..8.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_val  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  per-requester request ready.
- req_msg  in  NREQ*64  request i occupies [64*i+63:64*i]; operand a in [63:32], operand b in [31:0].
- resp_val  out  NREQ  per-requester response valid.
- resp_rdy  in  NREQ  per-requester response ready.
- resp_msg  out  32  product, shared by all requesters; qualified by resp_val.
- mul_istream_val / mul_istream_rdy  out / in  1  multiplier input handshake.
- mul_istream_msg  out  64  muxed request message.
- mul_ostream_val / mul_ostream_rdy  in / out  1  multiplier output handshake.
- mul_ostream_msg  in  32  multiplier product.
- outstanding  out  $clog2(MAX_OUT)+1  tag FIFO occupancy.

## Operation
- State: round-robin pointer ptr (TW bits); tag FIFO with MAX_OUT entries (each entry TW bits) and head, tail and count.
- Grant (combinational): g = the first i with req_val[i] = 1, scanning ptr, ptr+1, … modulo NREQ. If no request is valid, there is no grant.
- mul_istream_val = grant exists && count != MAX_OUT.
- mul_istream_msg = req_msg[g]. When there is no grant, this output is don't-care.
- req_rdy[g] = mul_istream_rdy && count != MAX_OUT. All other req_rdy bits are 0.
- Issue fire (mul_istream_val && mul_istream_rdy): push g onto the tag FIFO, then set ptr = (g+1) mod NREQ.
- ptr is unchanged on cycles with no fire, including cycles with a grant but a stalled multiplier.
- Response steering uses the tag at the FIFO head, h:
  - resp_val[h] = mul_ostream_val && count != 0. All other resp_val bits are 0.
  - resp_msg = mul_ostream_msg.
  - mul_ostream_rdy = resp_rdy[h] && count != 0.
- Response fire: pop the FIFO.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- A full FIFO blocks push even when a pop occurs in the same cycle. req_rdy depends only on the registered count; there is no same-cycle bypass.
- Empty FIFO with mul_ostream_val = 1 is a protocol violation. mul_ostream_rdy stays 0 and no resp_val is raised.
- Requesters must hold req_val and req_msg stable until they see rdy. A requester may drop req_val before its fire; the grant then moves to the next valid requester in the same cycle.

## Timing
- Reset values: ptr = 0, head = tail = count = 0, outstanding = 0.
- While reset = 0, all val/rdy outputs are forced to 0: req_rdy, resp_val, mul_istream_val, mul_ostream_rdy.
- Reset mid-operation: tags in flight are discarded with no response. The multiplier must share the same reset.
- Added latency is zero on both paths: the request-to-multiplier and multiplier-to-response paths are combinational pass-through.
- End-to-end latency equals the multiplier latency.
- Throughput is one issue per cycle when the multiplier permits it.
- A requester whose req_val is held is granted within NREQ issue fires (starvation bound).
- Responses return in issue order; the multiplier must be in-order.
- outstanding is the registered count and updates on the clock edge after a push or pop.

## Test plan
- Single requester: req 2 sends a = 7648, b = 7648.
  - Required: req_rdy[2] is high only for that request, resp_val[2] = 1 and resp_msg = 58491904, other resp_val bits stay 0, and ptr becomes 3.
- All four requesters valid every cycle, starting from reset, each holding its own operands (the P_Test values):
  - Grant order is 0, 1, 2, 3, 0, … and every response goes to the port that issued the request.
- Back-pressure: resp_rdy[1] = 0 for 20 cycles while req 1 has a = 4096, b = 2048 outstanding.
  - Required: resp_val[1] stays high with resp_msg = 8388608, mul_ostream_rdy = 0, and with MAX_OUT = 2 a third issue is blocked (outstanding = 2).
- Full FIFO with a same-cycle pop: no new issue in that cycle; the issue happens on the next cycle.
- Reset asserted (reset = 0) mid-operation with 2 operations outstanding:
  - Required: all val/rdy outputs go to 0 immediately, and after release outstanding = 0 and ptr = 0.
- Random test: 100 $random operand pairs spread across random requesters, with random resp_rdy stalls.
  - Required: every product equals a*b (low 32 bits), it is delivered to the port that issued it, and per-port response order matches issue order.
